// File: rtl/rstcon_pkg.sv
// Shared definitions for the reset request controller.
// Holds the FSM state encoding, the reset-cause codes, the parameter
// defaults and a small helper used to size the shared sequence counter.
package rstcon_pkg;

  localparam int HOLD_CYCLES_DEF = 16;
  localparam int STAGE_GAP_DEF   = 4;
  localparam int ACK_TIMEOUT_DEF = 255;

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_SW  = 2'b01;
  localparam logic [1:0] CAUSE_WDT = 2'b10;
  localparam logic [1:0] CAUSE_EXT = 2'b11;

  typedef enum logic [3:0] {
    IDLE,
    DRAIN,
    ASSERT_C,
    ASSERT_B,
    ASSERT_A,
    HOLD,
    REL_A,
    REL_B,
    REL_C
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction

endpackage

// File: rtl/rst_seq_counter.sv
// Shared down-counter for gap, hold and drain-timeout intervals.
// Ports:
//   clk      - clock, rising edge
//   load     - load a new interval length (takes priority over dec)
//   load_val - interval length in cycles (>= 1)
//   dec      - count one cycle of the current interval
//   zero     - high during the last cycle of the loaded interval
// The counter stores "cycles remaining minus one", so an interval of N
// cycles shows zero in exactly its N-th cycle. It has no reset of its own:
// the controller loads it every cycle its reset is asserted.
module rst_seq_counter #(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val - ONE;
    else if (dec && (cnt_q != '0))
      cnt_d = cnt_q - ONE;
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/reset_request_ctrl.sv
// Reset request controller: collects sw / watchdog / external reset
// requests, drains downstream traffic, then asserts rst_c, rst_b, rst_a in
// staggered order, holds them, and releases rst_a, rst_b, rst_c in turn.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   sw/wdt/ext_rst_req          - reset requests (sampled in IDLE; ext also aborts DRAIN)
//   quiesce_ack / quiesce_req   - drain handshake with downstream
//   rst_a, rst_b, rst_c         - staged reset outputs (registered)
//   busy                        - any state but IDLE
//   rst_cause                   - cause of the last sequence
//   ack_timeout                 - last drain ended by timeout
// Timing: ASSERT_C and ASSERT_B each last STAGE_GAP cycles. ASSERT_A is the
// first cycle with all three resets high; HOLD supplies the remaining
// HOLD_CYCLES-1. REL_A lasts STAGE_GAP; REL_B is the cycle rst_b falls and
// REL_C the rest of that gap, so every edge is STAGE_GAP apart.
module reset_request_ctrl
  import rstcon_pkg::*;
#(
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int STAGE_GAP   = STAGE_GAP_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_rst_req,
  input  logic       wdt_rst_req,
  input  logic       ext_rst_req,
  input  logic       quiesce_ack,
  output logic       quiesce_req,
  output logic       rst_a,
  output logic       rst_b,
  output logic       rst_c,
  output logic       busy,
  output logic [1:0] rst_cause,
  output logic       ack_timeout
);

  localparam int CNT_W = $clog2(max3(HOLD_CYCLES, STAGE_GAP, ACK_TIMEOUT)) + 1;

  localparam logic [CNT_W-1:0] HOLD_N  = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_N1 = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_N   = CNT_W'(STAGE_GAP);
  localparam logic [CNT_W-1:0] GAP_N1  = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] TMO_N   = CNT_W'(ACK_TIMEOUT);

  state_e     state_q, state_d;
  logic [1:0] cause_q, cause_d;
  logic       ack_to_q, ack_to_d;
  logic       rst_a_q, rst_b_q, rst_c_q, busy_q, qreq_q;
  logic       rst_a_d, rst_b_d, rst_c_d, busy_d;

  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_val;

  rst_seq_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    ack_to_d = ack_to_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ext_rst_req || wdt_rst_req || sw_rst_req) begin
          state_d  = DRAIN;
          cnt_load = 1'b1;
          cnt_val  = TMO_N;
          if (ext_rst_req)      cause_d = CAUSE_EXT;
          else if (wdt_rst_req) cause_d = CAUSE_WDT;
          else                  cause_d = CAUSE_SW;
        end
      end
      DRAIN: begin
        // ext aborts the wait outright; ack beats a timeout in the same cycle
        if (ext_rst_req || quiesce_ack || cnt_zero) begin
          state_d  = ASSERT_C;
          cnt_load = 1'b1;
          cnt_val  = GAP_N;
          ack_to_d = !ext_rst_req && !quiesce_ack;
          if (ext_rst_req) cause_d = CAUSE_EXT;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ASSERT_C: begin
        if (cnt_zero) begin
          state_d  = ASSERT_B;
          cnt_load = 1'b1;
          cnt_val  = GAP_N;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ASSERT_B: begin
        if (cnt_zero) state_d = ASSERT_A;
        else          cnt_dec = 1'b1;
      end
      ASSERT_A: begin
        cnt_load = 1'b1;
        if (HOLD_CYCLES == 1) begin
          state_d = REL_A;
          cnt_val = GAP_N;
        end else begin
          state_d = HOLD;
          cnt_val = HOLD_N1;
        end
      end
      HOLD: begin
        if (cnt_zero) begin
          state_d  = REL_A;
          cnt_load = 1'b1;
          cnt_val  = GAP_N;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      REL_A: begin
        if (cnt_zero) state_d = REL_B;
        else          cnt_dec = 1'b1;
      end
      REL_B: begin
        if (STAGE_GAP == 1) begin
          state_d = IDLE;
        end else begin
          state_d  = REL_C;
          cnt_load = 1'b1;
          cnt_val  = GAP_N1;
        end
      end
      REL_C: begin
        if (cnt_zero) state_d = IDLE;
        else          cnt_dec = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // reset parks the FSM in HOLD with a full hold interval pending
    if (rst) begin
      cnt_load = 1'b1;
      cnt_val  = HOLD_N;
      cnt_dec  = 1'b0;
    end
  end

  // outputs are decoded from the next state so they change on the same
  // edge as the state register, yet are driven straight from flops
  always_comb begin
    rst_c_d = (state_d != IDLE) && (state_d != DRAIN);
    rst_b_d = (state_d == ASSERT_B) || (state_d == ASSERT_A) ||
              (state_d == HOLD) || (state_d == REL_A);
    rst_a_d = (state_d == ASSERT_A) || (state_d == HOLD);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HOLD;
      cause_q  <= CAUSE_POR;
      ack_to_q <= 1'b0;
      rst_a_q  <= 1'b1;
      rst_b_q  <= 1'b1;
      rst_c_q  <= 1'b1;
      busy_q   <= 1'b1;
      qreq_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      ack_to_q <= ack_to_d;
      rst_a_q  <= rst_a_d;
      rst_b_q  <= rst_b_d;
      rst_c_q  <= rst_c_d;
      busy_q   <= busy_d;
      qreq_q   <= busy_d;
    end
  end

  assign rst_a       = rst_a_q;
  assign rst_b       = rst_b_q;
  assign rst_c       = rst_c_q;
  assign busy        = busy_q;
  assign quiesce_req = qreq_q;
  assign rst_cause   = cause_q;
  assign ack_timeout = ack_to_q;

endmodule

// File: tb/tb_reset_request_ctrl.sv
// Bench for reset_request_ctrl: a timeline model (each sequence is a base
// cycle plus fixed offsets for every reset edge) checked every cycle, a few
// directed scenarios with literal timing expectations, then random traffic.
module tb_reset_request_ctrl;

  localparam int H = 16;
  localparam int G = 4;
  localparam int T = 255;
  localparam int SEQ_LEN = 4 * G + H;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sw = 1'b0, wdt = 1'b0, ext = 1'b0, ack = 1'b0;
  logic       qreq, ra, rb, rc, busy, ato;
  logic [1:0] cause;

  int checks = 0;
  int errors = 0;

  reset_request_ctrl #(.HOLD_CYCLES(H), .STAGE_GAP(G), .ACK_TIMEOUT(T)) dut (
    .clk         (clk),
    .rst         (rst),
    .sw_rst_req  (sw),
    .wdt_rst_req (wdt),
    .ext_rst_req (ext),
    .quiesce_ack (ack),
    .quiesce_req (qreq),
    .rst_a       (ra),
    .rst_b       (rb),
    .rst_c       (rc),
    .busy        (busy),
    .rst_cause   (cause),
    .ack_timeout (ato)
  );

  always #5 clk = ~clk;

  // ---------------- model ----------------
  // n = index of the latest rising edge; cycle n is the time after it.
  // base = first cycle rst_c is high for the current sequence. A reset
  // pins base so the all-high window starts in the cycle after rst.
  int         n = 0;
  int         base = -100000;
  bit         m_drain = 1'b0;
  int         d_start = 0;
  logic [1:0] m_cause = 2'b00;
  logic       m_to = 1'b0;
  bit         chk_en = 1'b0;

  always @(posedge clk) begin
    n <= n + 1;
    if (rst) begin
      base    <= n + 1 - 2 * G;
      m_drain <= 1'b0;
      m_cause <= 2'b00;
      m_to    <= 1'b0;
      chk_en  <= 1'b1;
    end else if (m_drain) begin
      if (ext) begin
        base <= n + 1; m_drain <= 1'b0; m_cause <= 2'b11; m_to <= 1'b0;
      end else if (ack) begin
        base <= n + 1; m_drain <= 1'b0; m_to <= 1'b0;
      end else if (n + 1 - d_start == T) begin
        base <= n + 1; m_drain <= 1'b0; m_to <= 1'b1;
      end
    end else if ((n >= base + SEQ_LEN) && (sw || wdt || ext)) begin
      m_drain <= 1'b1;
      d_start <= n + 1;
      m_cause <= ext ? 2'b11 : (wdt ? 2'b10 : 2'b01);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, n);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      logic e_a, e_b, e_c, e_busy;
      e_c    = !m_drain && (n >= base) && (n < base + SEQ_LEN);
      e_b    = !m_drain && (n >= base + G) && (n < base + 3 * G + H);
      e_a    = !m_drain && (n >= base + 2 * G) && (n < base + 2 * G + H);
      e_busy = m_drain || e_c;
      chk("m_rst_a", ra, e_a);
      chk("m_rst_b", rb, e_b);
      chk("m_rst_c", rc, e_c);
      chk("m_busy", busy, e_busy);
      chk("m_quiesce_req", qreq, e_busy);
      chk("m_rst_cause", cause, m_cause);
      chk("m_ack_timeout", ato, m_to);
    end
  end

  // ---------------- directed helpers ----------------
  function automatic logic sig_sel(input int s);
    case (s)
      0:       return ra;
      1:       return rb;
      2:       return rc;
      default: return busy;
    endcase
  endfunction

  // negedges until the selected output equals v (bounded)
  task automatic count_until(input int s, input logic v, output int cnt);
    cnt = 0;
    while (sig_sel(s) !== v && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  initial begin
    int c;
    int ack_div;

    // power-on style reset: 5 cycles high
    repeat (5) @(negedge clk);
    chk("por_all_high", {ra, rb, rc, busy, qreq}, 5'b11111);
    chk("por_cause", cause, 2'b00);
    chk("por_ack_timeout", ato, 1'b0);
    rst = 1'b0;
    count_until(0, 1'b0, c); chk("por_a_fall", c, 16);
    count_until(1, 1'b0, c); chk("por_b_fall", c, 4);
    count_until(2, 1'b0, c); chk("por_c_fall", c, 4);
    chk("por_idle", busy, 1'b0);

    // sw pulse, ack three cycles later
    @(negedge clk); sw = 1'b1;
    @(negedge clk); sw = 1'b0;
    repeat (2) @(negedge clk);
    chk("sw_drain_qreq", {qreq, rc}, 2'b10);
    ack = 1'b1;
    count_until(2, 1'b1, c); chk("sw_c_rise", c, 1);
    ack = 1'b0;
    count_until(1, 1'b1, c); chk("sw_b_rise", c, 4);
    count_until(0, 1'b1, c); chk("sw_a_rise", c, 4);
    chk("sw_cause", cause, 2'b01);
    chk("sw_ack_timeout", ato, 1'b0);
    count_until(3, 1'b0, c); chk("sw_busy_fall", c, 24);

    // wdt with ack never arriving
    @(negedge clk); wdt = 1'b1;
    @(negedge clk); wdt = 1'b0;
    count_until(2, 1'b1, c); chk("wdt_drain_len", c, 255);
    chk("wdt_ack_timeout", ato, 1'b1);
    chk("wdt_cause", cause, 2'b10);
    count_until(3, 1'b0, c); chk("wdt_busy_fall", c, 32);

    // sw+ext together, then ext again during the drain
    @(negedge clk); sw = 1'b1; ext = 1'b1;
    @(negedge clk); sw = 1'b0; ext = 1'b0;
    chk("ext_cause_latch", cause, 2'b11);
    repeat (4) @(negedge clk);
    chk("ext_still_drain", {busy, rc}, 2'b10);
    ext = 1'b1;
    count_until(2, 1'b1, c); chk("ext_abort_c_rise", c, 1);
    ext = 1'b0;
    chk("ext_ack_timeout", ato, 1'b0);
    count_until(3, 1'b0, c);

    // ack already high on drain entry; sw during HOLD ignored
    @(negedge clk); sw = 1'b1; ack = 1'b1;
    @(negedge clk); sw = 1'b0;
    count_until(2, 1'b1, c); chk("ack_early_drain_1", c, 1);
    ack = 1'b0;
    count_until(0, 1'b1, c); chk("hold_a_rise", c, 8);
    sw = 1'b1;
    @(negedge clk); sw = 1'b0;
    count_until(3, 1'b0, c); chk("hold_busy_fall", c, 23);
    chk("hold_c_with_busy", rc, 1'b0);
    repeat (5) @(negedge clk);
    chk("hold_req_not_queued", busy, 1'b0);

    // rst pulse after rst_b released
    @(negedge clk); sw = 1'b1; ack = 1'b1;
    @(negedge clk); sw = 1'b0;
    count_until(2, 1'b1, c);
    ack = 1'b0;
    count_until(1, 1'b0, c);
    chk("relb_state", {ra, rb, rc}, 3'b001);
    rst = 1'b1;
    @(negedge clk);
    chk("relb_rst_all_high", {ra, rb, rc}, 3'b111);
    chk("relb_rst_cause", cause, 2'b00);
    rst = 1'b0;
    count_until(0, 1'b0, c); chk("relb_rst_a_fall", c, 16);

    // random traffic, model-checked each cycle
    for (int seg = 0; seg < 16; seg++) begin
      ack_div = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 10));
      for (int i = 0; i < 500; i++) begin
        @(negedge clk);
        sw  = ($urandom_range(0, 19) == 0);
        wdt = ($urandom_range(0, 29) == 0);
        ext = ($urandom_range(0, 59) == 0);
        ack = (ack_div != 0) && ($urandom_range(0, ack_div - 1) == 0);
        rst = ($urandom_range(0, 399) == 0);
      end
    end
    @(negedge clk);
    sw = 1'b0; wdt = 1'b0; ext = 1'b0; ack = 1'b1; rst = 1'b0;
    repeat (60) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reset_request_ctrl.md
RESET_REQUEST_CTRL -- requirements
Module: reset_request_ctrl

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 16: cycles all resets are held asserted, minimum 1.
REQ-002 SHALL have parameter STAGE_GAP, default 4: cycles between consecutive stage assert or release edges, minimum 1.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 255: maximum cycles to wait for quiesce_ack, minimum 1.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port sw_rst_req, input, 1 bit: software reset request, level, sampled in IDLE.
REQ-007 SHALL have port wdt_rst_req, input, 1 bit: watchdog reset request, level, sampled in IDLE.
REQ-008 SHALL have port ext_rst_req, input, 1 bit: external reset request, already synchronized to clk.
REQ-009 SHALL have port quiesce_ack, input, 1 bit: downstream confirms outstanding traffic drained.
REQ-010 SHALL have port quiesce_req, output, 1 bit: asks downstream to stop issuing and drain.
REQ-011 SHALL have port rst_a, output, 1 bit: stage-A reset, active-high, released first.
REQ-012 SHALL have port rst_b, output, 1 bit: stage-B reset, active-high.
REQ-013 SHALL have port rst_c, output, 1 bit: stage-C reset, active-high, released last.
REQ-014 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-015 SHALL have port rst_cause, output, 2 bits: last cause; 00 power-on, 01 sw, 10 wdt, 11 ext.
REQ-016 SHALL have port ack_timeout, output, 1 bit: last drain ended by timeout, not by quiesce_ack.

Function
REQ-017 SHALL implement states IDLE, DRAIN, ASSERT_C, ASSERT_B, ASSERT_A, HOLD, REL_A, REL_B, REL_C.
REQ-018 In IDLE, any request high SHALL move the FSM to DRAIN next cycle and latch rst_cause with priority ext > wdt > sw.
REQ-019 DRAIN SHALL drive quiesce_req=1 and advance when quiesce_ack=1 or after ACK_TIMEOUT cycles; ack_timeout records which occurred.
REQ-020 If quiesce_ack is already high on DRAIN entry, the FSM SHALL leave DRAIN after exactly 1 cycle.
REQ-021 ext_rst_req during DRAIN SHALL abort the wait, go to ASSERT_C next cycle and set rst_cause=11.
REQ-022 Assertion order SHALL be rst_c, then rst_b, then rst_a, each edge STAGE_GAP cycles after the previous one.
REQ-023 HOLD SHALL keep all three resets high for exactly HOLD_CYCLES cycles.
REQ-024 Release order SHALL be rst_a, then rst_b, then rst_c, each edge STAGE_GAP cycles apart; IDLE is entered in the cycle rst_c falls.
REQ-025 quiesce_req SHALL stay high from DRAIN entry until rst_c is released.
REQ-026 New requests outside IDLE SHALL be ignored and not queued; a request still held high at return to IDLE starts a new sequence.
REQ-027 Reset outputs SHALL be register outputs with no combinational path from any input.
REQ-028 One shared down-counter SHALL serve gap, hold and timeout; width SHALL be clog2 of the largest parameter plus 1.

Reset
REQ-029 While rst=1: rst_a=rst_b=rst_c=1, quiesce_req=1, busy=1, rst_cause=00, ack_timeout=0, and the FSM is forced to HOLD with the counter loaded to HOLD_CYCLES.
REQ-030 After rst falls, the normal HOLD, REL_A, REL_B, REL_C sequence SHALL run with no DRAIN.
REQ-031 rst asserted mid-sequence SHALL override everything within one cycle.

Structure
REQ-032 The state encoding, cause codes (CAUSE_POR/SW/WDT/EXT) and parameter defaults SHALL live in shared package rstcon_pkg.
REQ-033 The counter SHALL be a sub-module rst_seq_counter (load, decrement, zero flag); everything else is flat.

Verification
REQ-034 rst high 5 cycles, then low -> rst_a falls after 16 cycles, rst_b 4 cycles later, rst_c 4 later, rst_cause=00.
REQ-035 sw_rst_req pulse, quiesce_ack 3 cycles later -> rst_c rises 1 cycle after ack, then rst_b +4, rst_a +4; rst_cause=01, ack_timeout=0.
REQ-036 wdt_rst_req with quiesce_ack held low -> DRAIN lasts 255 cycles, ack_timeout=1, rst_cause=10.
REQ-037 sw and ext requests in the same cycle -> rst_cause=11; an ext request during DRAIN skips the remaining wait.
REQ-038 sw request during HOLD -> ignored, and busy falls when rst_c releases; rst pulse during REL_B -> all resets high next cycle.
